mc_control_fsm: RTL and testbench
=================================

Name: mc_control_fsm

Overview:
Multicycle control unit that sequences IFSTAGE, DECSTAGE, EXSTAGE and MEMSTAGE, one instruction at a time. It decodes the IR opcode and func fields and walks a per-class state sequence. Each cycle it drives the enables and selects for the PC, IR, register file, ALU and data memory. It is the sole driver of PC_LdEn and PC_sel in the processor top level.

Parameters:
ALU_ADD, 4'b0000, ALU_func code for add (address calc, addi, li, lui)
ALU_SUB, 4'b0001, ALU_func code for subtract (beq/bne compare)
ALU_AND, 4'b0010, ALU_func code for andi
ALU_OR, 4'b0011, ALU_func code for ori

Ports:
clk  in  1  system clock, rising edge
Reset  in  1  synchronous, active-high
Opcode  in  6  IR[31:26]
Func  in  6  IR[5:0], R-type ALU op
Zero  in  1  ALU zero flag, valid in BRANCH state
PC_LdEn  out  1  PC register load enable
PC_sel  out  1  0: PC+4, 1: PC+4+(Immed<<2)
IR_LdEn  out  1  instruction register load
RF_WrEn  out  1  register file write
RF_WrData_sel  out  1  0: ALU result, 1: memory data
RF_B_sel  out  1  0: rt, 1: rd as second read address
ALU_Bin_sel  out  1  0: RF_B, 1: extended immediate
ALU_func  out  4  ALU operation
ImmExt  out  2  00 sign-ext, 01 zero-ext, 10 <<16 zero-fill, 11 sign-ext<<2
MEM_WrEn  out  1  data memory write
ByteOp  out  1  1 for lb/sb
Busy  out  1  0 only in FETCH

Behaviour:
- Fixed opcodes: 100000 R-type; 111000 li; 111001 lui; 110000 addi; 110010 andi; 110011 ori; 111111 b; 000000 beq; 000001 bne; 000011 lb; 000111 sb; 001111 lw; 011111 sw.
- States: FETCH, DECODE, EXEC_R, EXEC_I, ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH. Encoding is free; a 4-bit state register.
- Sync Reset: state <- FETCH. All outputs 0 during the Reset cycle and the first FETCH cycle except IR_LdEn.
- Reset overrides every transition, including mid-instruction. No writes (RF_WrEn, MEM_WrEn, PC_LdEn) may occur in the Reset cycle.
- FETCH: IR_LdEn=1. Next state DECODE.
- DECODE: register read. RF_B_sel=1 for every non-R-type. Next state:
  - R-type -> EXEC_R
  - li/lui/addi/andi/ori -> EXEC_I
  - lb/lw/sb/sw -> ADDR
  - beq/bne -> BRANCH
  - b: PC_LdEn=1, PC_sel=1, then FETCH
- EXEC_R: ALU_func=Func[3:0], ALU_Bin_sel=0. Next WB_ALU.
- EXEC_I: ALU_Bin_sel=1. ALU_func: ALU_AND for andi, ALU_OR for ori, else ALU_ADD. ImmExt: 10 for lui, 01 for andi/ori, else 00. Next WB_ALU.
- ADDR: ALU_Bin_sel=1, ALU_ADD, ImmExt=00. Next MEM_RD for loads, MEM_WR for stores.
- MEM_RD: ByteOp per opcode. Next WB_MEM.
- MEM_WR: MEM_WrEn=1, ByteOp per opcode, PC_LdEn=1, PC_sel=0. Next FETCH.
- WB_ALU: RF_WrEn=1, RF_WrData_sel=0, ALU controls held from the previous state, PC_LdEn=1, PC_sel=0. Next FETCH.
- WB_MEM: RF_WrEn=1, RF_WrData_sel=1, PC_LdEn=1, PC_sel=0. Next FETCH.
- BRANCH: ALU_SUB, ALU_Bin_sel=0, ImmExt=11, PC_LdEn=1. PC_sel = Zero for beq, ~Zero for bne; this is the only Mealy output. Next FETCH.
- PC_LdEn is high in exactly one cycle per instruction, always the final state.
- Latency in cycles (FETCH to next FETCH exclusive): b 2; beq/bne 3; R/I-type 4; stores 4; loads 5.
- Unlisted opcode: see Optional Feature.

Optional Feature:
Macro ILLEGAL_OP_TRAP_EN.
- Defined: an unlisted opcode in DECODE moves to HALT. HALT asserts output Trap=1 and drives all enables 0, so the PC is frozen. HALT is left only by Reset; the Trap port exists only under the macro.
- Undefined: an unlisted opcode is a NOP. DECODE asserts PC_LdEn=1, PC_sel=0, then FETCH (2 cycles).

Test Plan:
- Reset=1 for 2 cycles, then R-type Opcode 100000, Func 110000 -> states FETCH, DECODE, EXEC_R, WB_ALU. ALU_func=0000 in EXEC_R. RF_WrEn=1 and PC_LdEn=1 only in cycle 4. IR_LdEn=1 only in cycle 1.
- lw (001111) -> 5 cycles. MEM_WrEn=0 throughout. WB_MEM has RF_WrData_sel=1, RF_WrEn=1, PC_LdEn=1. ByteOp=0.
- sb (000111) -> 4 cycles. MEM_WR has MEM_WrEn=1, ByteOp=1, PC_LdEn=1. RF_WrEn never 1.
- beq with Zero=1 -> BRANCH PC_sel=1. bne with Zero=1 -> PC_sel=0. b -> PC_LdEn=1, PC_sel=1 in DECODE, 2 cycles total.
- Reset asserted in MEM_RD of lw -> next cycle is FETCH. No RF_WrEn or PC_LdEn pulse occurs.
- Opcode 010101 -> without macro: PC_LdEn in DECODE, then FETCH. With ILLEGAL_OP_TRAP_EN: Trap=1 held and PC_LdEn=0 for 10+ cycles until Reset.

Source files
------------

// File: rtl/mc_control_fsm.sv
// Multicycle control FSM: fetch/decode/execute/memory/writeback sequencing.
// Optional macro ILLEGAL_OP_TRAP_EN: unlisted opcodes halt with Trap=1.
module mc_control_fsm (
  input  logic       clk,
  input  logic       Reset,
  input  logic [5:0] Opcode,
  input  logic [5:0] Func,
  input  logic       Zero,
  output logic       PC_LdEn,
  output logic       PC_sel,
  output logic       IR_LdEn,
  output logic       RF_WrEn,
  output logic       RF_WrData_sel,
  output logic       RF_B_sel,
  output logic       ALU_Bin_sel,
  output logic [3:0] ALU_func,
  output logic [1:0] ImmExt,
  output logic       MEM_WrEn,
  output logic       ByteOp,
  output logic       Busy
`ifdef ILLEGAL_OP_TRAP_EN
  ,
  output logic       Trap
`endif
);

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_EXEC_R = 4'd2;
  localparam logic [3:0] S_EXEC_I = 4'd3;
  localparam logic [3:0] S_ADDR   = 4'd4;
  localparam logic [3:0] S_MEM_RD = 4'd5;
  localparam logic [3:0] S_MEM_WR = 4'd6;
  localparam logic [3:0] S_WB_ALU = 4'd7;
  localparam logic [3:0] S_WB_MEM = 4'd8;
  localparam logic [3:0] S_BRANCH = 4'd9;
`ifdef ILLEGAL_OP_TRAP_EN
  localparam logic [3:0] S_HALT   = 4'd10;
`endif

  localparam logic [5:0] OP_R    = 6'b100000;
  localparam logic [5:0] OP_LI   = 6'b111000;
  localparam logic [5:0] OP_LUI  = 6'b111001;
  localparam logic [5:0] OP_ADDI = 6'b110000;
  localparam logic [5:0] OP_ANDI = 6'b110010;
  localparam logic [5:0] OP_ORI  = 6'b110011;
  localparam logic [5:0] OP_B    = 6'b111111;
  localparam logic [5:0] OP_BEQ  = 6'b000000;
  localparam logic [5:0] OP_BNE  = 6'b000001;
  localparam logic [5:0] OP_LB   = 6'b000011;
  localparam logic [5:0] OP_SB   = 6'b000111;
  localparam logic [5:0] OP_LW   = 6'b001111;
  localparam logic [5:0] OP_SW   = 6'b011111;

  logic [3:0] state;
  logic [3:0] next;

  logic is_r, is_li, is_lui, is_addi;
  logic is_andi, is_ori, is_b;
  logic is_beq, is_bne;
  logic is_lb, is_sb, is_lw, is_sw;
  logic is_imm, is_load, is_store, is_cbr;
  logic func_unused;

  logic [3:0] imm_func;
  logic [1:0] imm_ext;

  assign is_r    = (Opcode == OP_R);
  assign is_li   = (Opcode == OP_LI);
  assign is_lui  = (Opcode == OP_LUI);
  assign is_addi = (Opcode == OP_ADDI);
  assign is_andi = (Opcode == OP_ANDI);
  assign is_ori  = (Opcode == OP_ORI);
  assign is_b    = (Opcode == OP_B);
  assign is_beq  = (Opcode == OP_BEQ);
  assign is_bne  = (Opcode == OP_BNE);
  assign is_lb   = (Opcode == OP_LB);
  assign is_sb   = (Opcode == OP_SB);
  assign is_lw   = (Opcode == OP_LW);
  assign is_sw   = (Opcode == OP_SW);

  assign is_imm   = is_li | is_lui | is_addi
                  | is_andi | is_ori;
  assign is_load  = is_lb | is_lw;
  assign is_store = is_sb | is_sw;
  assign is_cbr   = is_beq | is_bne;

  // Only the low nibble of Func selects the ALU op.
  assign func_unused = ^Func[5:4];

  assign imm_func = is_andi ? ALU_AND
                  : is_ori  ? ALU_OR
                  : ALU_ADD;
  assign imm_ext  = is_lui             ? 2'b10
                  : (is_andi | is_ori) ? 2'b01
                  : 2'b00;

  always_ff @(posedge clk) begin
    if (Reset) state <= S_FETCH;
    else       state <= next;
  end

  always_comb begin
    next = S_FETCH;
    unique case (state)
      S_FETCH: next = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          is_r:                next = S_EXEC_R;
          is_imm:              next = S_EXEC_I;
          is_load | is_store:  next = S_ADDR;
          is_cbr:              next = S_BRANCH;
          is_b:                next = S_FETCH;
`ifdef ILLEGAL_OP_TRAP_EN
          default:             next = S_HALT;
`else
          default:             next = S_FETCH;
`endif
        endcase
      end
      S_EXEC_R: next = S_WB_ALU;
      S_EXEC_I: next = S_WB_ALU;
      S_ADDR:   next = is_load ? S_MEM_RD
                               : S_MEM_WR;
      S_MEM_RD: next = S_WB_MEM;
      S_WB_ALU: next = S_FETCH;
      S_WB_MEM: next = S_FETCH;
      S_MEM_WR: next = S_FETCH;
      S_BRANCH: next = S_FETCH;
`ifdef ILLEGAL_OP_TRAP_EN
      S_HALT:   next = S_HALT;
`endif
      default:  next = S_FETCH;
    endcase
  end

  // Everything is forced low while Reset is high, whatever the state.
  always_comb begin
    PC_LdEn       = 1'b0;
    PC_sel        = 1'b0;
    IR_LdEn       = 1'b0;
    RF_WrEn       = 1'b0;
    RF_WrData_sel = 1'b0;
    RF_B_sel      = 1'b0;
    ALU_Bin_sel   = 1'b0;
    ALU_func      = ALU_ADD;
    ImmExt        = 2'b00;
    MEM_WrEn      = 1'b0;
    ByteOp        = 1'b0;
    Busy          = 1'b0;
`ifdef ILLEGAL_OP_TRAP_EN
    Trap          = 1'b0;
`endif
    if (!Reset) begin
      Busy = (state != S_FETCH);
      unique case (state)
        S_FETCH: IR_LdEn = 1'b1;
        S_DECODE: begin
          RF_B_sel = ~is_r;
          if (is_b) begin
            PC_LdEn = 1'b1;
            PC_sel  = 1'b1;
          end
`ifndef ILLEGAL_OP_TRAP_EN
          if (!(is_r | is_imm | is_load
                | is_store | is_cbr | is_b))
            PC_LdEn = 1'b1;
`endif
        end
        S_EXEC_R: ALU_func = Func[3:0];
        S_EXEC_I: begin
          ALU_Bin_sel = 1'b1;
          ALU_func    = imm_func;
          ImmExt      = imm_ext;
        end
        S_ADDR: ALU_Bin_sel = 1'b1;
        S_MEM_RD: ByteOp = is_lb;
        S_MEM_WR: begin
          MEM_WrEn = 1'b1;
          ByteOp   = is_sb;
          PC_LdEn  = 1'b1;
        end
        S_WB_ALU: begin
          RF_WrEn     = 1'b1;
          PC_LdEn     = 1'b1;
          ALU_Bin_sel = ~is_r;
          ALU_func    = is_r ? Func[3:0]
                             : imm_func;
          ImmExt      = is_r ? 2'b00 : imm_ext;
        end
        S_WB_MEM: begin
          RF_WrEn       = 1'b1;
          RF_WrData_sel = 1'b1;
          PC_LdEn       = 1'b1;
        end
        S_BRANCH: begin
          ALU_func = ALU_SUB;
          ImmExt   = 2'b11;
          PC_LdEn  = 1'b1;
          PC_sel   = is_beq ? Zero : ~Zero;
        end
`ifdef ILLEGAL_OP_TRAP_EN
        S_HALT: Trap = 1'b1;
`endif
        default: Busy = 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Randomized bench for mc_control_fsm against a per-cycle instruction model.
// Build with ILLEGAL_OP_TRAP_EN to exercise the halt/trap variant.
module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       Reset = 1'b1;
  logic [5:0] Opcode = 6'd0;
  logic [5:0] Func = 6'd0;
  logic       Zero = 1'b0;
  logic       PC_LdEn, PC_sel, IR_LdEn, RF_WrEn;
  logic       RF_WrData_sel, RF_B_sel, ALU_Bin_sel;
  logic [3:0] ALU_func;
  logic [1:0] ImmExt;
  logic       MEM_WrEn, ByteOp, Busy;
  logic       trap_w;

`ifdef ILLEGAL_OP_TRAP_EN
  logic Trap;
  assign trap_w = Trap;
`else
  assign trap_w = 1'b0;
`endif

  mc_control_fsm dut (
    .clk(clk), .Reset(Reset),
    .Opcode(Opcode), .Func(Func), .Zero(Zero),
    .PC_LdEn(PC_LdEn), .PC_sel(PC_sel),
    .IR_LdEn(IR_LdEn), .RF_WrEn(RF_WrEn),
    .RF_WrData_sel(RF_WrData_sel),
    .RF_B_sel(RF_B_sel),
    .ALU_Bin_sel(ALU_Bin_sel),
    .ALU_func(ALU_func), .ImmExt(ImmExt),
    .MEM_WrEn(MEM_WrEn), .ByteOp(ByteOp),
    .Busy(Busy)
`ifdef ILLEGAL_OP_TRAP_EN
    , .Trap(Trap)
`endif
  );

  always #5 clk = ~clk;

  // Bit map: 16 Trap, 15 PC_LdEn, 14 PC_sel, 13 IR_LdEn,
  // 12 RF_WrEn, 11 WrData_sel, 10 RF_B_sel, 9 Bin_sel,
  // 8:5 ALU_func, 4:3 ImmExt, 2 MEM_WrEn, 1 ByteOp, 0 Busy.
  logic [16:0] dut_v;
  assign dut_v = {trap_w, PC_LdEn, PC_sel, IR_LdEn,
                  RF_WrEn, RF_WrData_sel, RF_B_sel,
                  ALU_Bin_sel, ALU_func, ImmExt,
                  MEM_WrEn, ByteOp, Busy};

  localparam logic [16:0] ALL  = 17'h1ffff;
  localparam logic [16:0] NOIR = 17'h1dfff;

  localparam int C_R = 0, C_I = 1, C_LD = 2, C_ST = 3;
  localparam int C_BR = 4, C_B = 5, C_ILL = 6;

  logic [5:0] ops [0:12] = '{
    6'b100000, 6'b111000, 6'b111001, 6'b110000,
    6'b110010, 6'b110011, 6'b111111, 6'b000000,
    6'b000001, 6'b000011, 6'b000111, 6'b001111,
    6'b011111};

  int checks = 0;
  int failures = 0;
  logic        exp_valid = 1'b0;
  logic [16:0] exp_v = '0;
  logic [16:0] exp_mask = ALL;
  int          cur_k = 0;
  logic [16:0] got [0:15];

  function automatic int cls_of(input logic [5:0] op);
    case (op)
      6'b100000: return C_R;
      6'b111000, 6'b111001, 6'b110000,
      6'b110010, 6'b110011: return C_I;
      6'b000011, 6'b001111: return C_LD;
      6'b000111, 6'b011111: return C_ST;
      6'b000000, 6'b000001: return C_BR;
      6'b111111: return C_B;
      default: return C_ILL;
    endcase
  endfunction

  function automatic int len_of(input logic [5:0] op);
    case (cls_of(op))
      C_LD: return 5;
      C_R, C_I, C_ST: return 4;
      C_BR: return 3;
      default: return 2;
    endcase
  endfunction

  // Expected outputs in cycle k of an instruction (k=0 is fetch).
  function automatic logic [16:0] model(
    input logic [5:0] op, input logic [5:0] fn,
    input logic z, input int k);
    logic [16:0] v;
    int c;
    v = '0;
    c = cls_of(op);
    v[0] = (k != 0);
    if (k == 0) v[13] = 1'b1;
    if (k == 1) begin
      v[10] = (c != C_R);
      if (c == C_B) v[15:14] = 2'b11;
`ifndef ILLEGAL_OP_TRAP_EN
      if (c == C_ILL) v[15] = 1'b1;
`endif
    end
`ifdef ILLEGAL_OP_TRAP_EN
    if (c == C_ILL && k >= 2) v[16] = 1'b1;
`endif
    if ((k == 2 || k == 3) && c == C_R)
      v[8:5] = fn[3:0];
    if ((k == 2 || k == 3) && c == C_I) begin
      v[9] = 1'b1;
      v[8:5] = (op == 6'b110010) ? 4'd2
             : (op == 6'b110011) ? 4'd3 : 4'd0;
      v[4:3] = (op == 6'b111001) ? 2'd2
             : (op == 6'b110010 || op == 6'b110011)
               ? 2'd1 : 2'd0;
    end
    if (k == 2 && (c == C_LD || c == C_ST)) v[9] = 1'b1;
    if (k == 2 && c == C_BR) begin
      v[8:5] = 4'd1;
      v[4:3] = 2'd3;
      v[15] = 1'b1;
      v[14] = (op == 6'b000000) ? z : ~z;
    end
    if (k == 3 && (c == C_R || c == C_I)) begin
      v[12] = 1'b1;
      v[15] = 1'b1;
    end
    if (k == 3 && c == C_LD) v[1] = (op == 6'b000011);
    if (k == 3 && c == C_ST) begin
      v[2] = 1'b1;
      v[1] = (op == 6'b000111);
      v[15] = 1'b1;
    end
    if (k == 4 && c == C_LD) begin
      v[12] = 1'b1;
      v[11] = 1'b1;
      v[15] = 1'b1;
    end
    return v;
  endfunction

  always @(negedge clk) begin
    if (exp_valid) begin
      checks++;
      if ((dut_v & exp_mask) !== (exp_v & exp_mask)) begin
        failures++;
        $display("FAIL cycle op=%b k=%0d got=%h exp=%h",
                 Opcode, cur_k, dut_v & exp_mask,
                 exp_v & exp_mask);
      end
    end
  end

  task automatic chk(input string name,
                     input logic [7:0] act,
                     input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, act, req);
    end
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      Reset = 1'b1;
      Func = 6'($urandom);
      Zero = 1'($urandom);
      exp_v = '0;
      exp_mask = NOIR;
      exp_valid = 1'b1;
      @(negedge clk);
      #1;
    end
  endtask

  // zsel<0 randomizes Zero each cycle; abort_at>=0 pulses Reset there.
  task automatic run_instr(input logic [5:0] op,
                           input logic [5:0] fn_r,
                           input int zsel,
                           input int abort_at,
                           input int ncyc);
    int n;
    n = (ncyc > 0) ? ncyc : len_of(op);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      Reset = (k == abort_at);
      Opcode = op;
      Func = (cls_of(op) == C_R) ? fn_r : 6'($urandom);
      Zero = (zsel < 0) ? 1'($urandom) : 1'(zsel);
      cur_k = k;
      if (Reset) begin
        exp_v = '0;
        exp_mask = NOIR;
      end else begin
        exp_v = model(op, Func, Zero, k);
        exp_mask = ALL;
      end
      exp_valid = 1'b1;
      @(negedge clk);
      #1;
      if (k < 16) got[k] = dut_v;
      if (k == abort_at) break;
    end
  endtask

  function automatic logic [7:0] col(input int b,
                                     input int n);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[i] = got[i][b];
    return r;
  endfunction

  initial begin
    logic [5:0] op;
    int pick, ab, top;
    @(posedge clk);
    #1;
    do_reset(2);

    run_instr(6'b100000, 6'b110000, -1, -1, 0);
    chk("r_alu_func", 8'(got[2][8:5]), 8'h00);
    chk("r_rfwr", col(12, 4), 8'b1000);
    chk("r_pcld", col(15, 4), 8'b1000);
    chk("r_irld", col(13, 4), 8'b0001);

    run_instr(6'b001111, 6'd0, -1, -1, 0);
    chk("lw_memwr", col(2, 5), 8'h00);
    chk("lw_byteop", col(1, 5), 8'h00);
    chk("lw_wbmem", 8'(got[4][15:11]), 8'b10011);

    run_instr(6'b000111, 6'd0, -1, -1, 0);
    chk("sb_memwr", 8'({got[3][15], got[3][2:1]}), 8'b111);
    chk("sb_rfwr", col(12, 4), 8'h00);

    run_instr(6'b000000, 6'd0, 1, -1, 0);
    chk("beq_z1_sel", 8'(got[2][15:14]), 8'b11);
    run_instr(6'b000001, 6'd0, 1, -1, 0);
    chk("bne_z1_sel", 8'(got[2][15:14]), 8'b10);
    run_instr(6'b111111, 6'd0, -1, -1, 0);
    chk("b_decode", 8'(got[1][15:14]), 8'b11);

    run_instr(6'b001111, 6'd0, -1, 3, 0);
    chk("abort_writes", 8'({got[3][15], got[3][12]}), 8'h0);
    run_instr(6'b100000, 6'b000011, -1, -1, 0);
    chk("abort_fetch", 8'({got[0][13], got[0][0]}), 8'b10);

`ifdef ILLEGAL_OP_TRAP_EN
    run_instr(6'b010101, 6'd0, -1, -1, 14);
    chk("trap_hold", col(16, 14), 8'hfc);
    chk("trap_pcld", col(15, 14), 8'h00);
    do_reset(1);
    top = 12;
`else
    run_instr(6'b010101, 6'd0, -1, -1, 0);
    chk("ill_nop", col(15, 2), 8'b10);
    top = 13;
`endif

    for (int t = 0; t < 250; t++) begin
      pick = $urandom_range(0, top);
      if (pick == 13) begin
        do op = 6'($urandom);
        while (cls_of(op) != C_ILL);
      end else begin
        op = ops[pick];
      end
      ab = ($urandom_range(0, 9) == 0)
         ? $urandom_range(0, len_of(op) - 1) : -1;
      run_instr(op, 6'($urandom), -1, ab, 0);
    end

    @(posedge clk);
    #1;
    exp_valid = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
